lbp_pixel_stream: RTL and testbench
===================================

Name: lbp_pixel_stream

Overview:
- Streaming Local Binary Pattern (LBP) operator directly upstream of the VGA controller.
- Consumes a raster pixel stream (RGB444) read from frame memory and converts each pixel to 4-bit gray.
- Builds a 3x3 window from two line buffers and emits one 12-bit pixel per input pixel: either the LBP code as gray or the delayed original pixel.
- Output feeds the VGA controller's 12-bit data_in, covering the 400x300 downsampled window.

Parameters:
- IMG_W, 400, pixels per line.
- IMG_H, 300, lines per frame.
- DATA_WIDTH, 12, pixel width, RGB444 = {R[11:8],G[7:4],B[3:0]}.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  synchronous active-high reset.
- in_data  in  DATA_WIDTH  input pixel.
- in_valid  in  1  input pixel present.
- in_sof  in  1  first pixel of frame; qualified by in_valid.
- in_ready  out  1  block accepts input this cycle.
- mode  in  1  1 = LBP output, 0 = pass-through; sampled on accepted in_sof.
- out_data  out  DATA_WIDTH  output pixel.
- out_valid  out  1  out_data valid; no backpressure.
- out_sof  out  1  first output pixel of frame.
- out_eof  out  1  last output pixel of frame.

Behaviour:
- Reset: all outputs 0 except in_ready = 1. FSM goes to IDLE; counters cleared. Line buffer contents are don't-care.
- Accept: an input pixel is accepted when in_valid && in_ready.
- Gray conversion: gray = (5*R + 9*G + 2*B) >> 4. Intermediate width is 8 bits; result is 4 bits, maximum 15.
- Line buffers: store raw 12-bit pixels. Two buffers of IMG_W entries each, plus 3x3 window registers.
- LBP code bits: bit=1 when neighbour gray >= centre gray. Bit order:
  - b7 = top-left, b6 = top, b5 = top-right, b4 = right
  - b3 = bottom-right, b2 = bottom, b1 = bottom-left, b0 = left
- Border: pixels with row 0, row IMG_H-1, col 0 or col IMG_W-1 get code 8'h00.
- Output data:
  - mode=1: out_data = {code[7:4], code[7:4], code[7:4]}.
  - mode=0: out_data = original pixel, delayed to the same alignment.
- Alignment: the output for input index k (raster order, 0..IMG_W*IMG_H-1) is registered one cycle after input index k+IMG_W+1 is accepted.
- FSM states:
  - IDLE: in_ready=1. Non-sof pixels are discarded. An accepted in_sof latches mode, sets in_col=1 and in_row=0, and moves to FILL.
  - FILL: accepts pixels with no output until IMG_W+1 pixels are accepted, then moves to RUN.
  - RUN: each accepted pixel produces exactly one output the next cycle. Input stalls (in_valid=0) produce no output. When the last input pixel (index IMG_W*IMG_H-1) is accepted, move to FLUSH.
  - FLUSH: in_ready=0. Emit the remaining IMG_W+1 outputs on consecutive cycles, out_valid=1 each cycle. Missing bottom-row neighbours are irrelevant because the bottom row is border. Then move to IDLE.
- Frame markers:
  - out_sof=1 only with output index 0.
  - out_eof=1 only with output index IMG_W*IMG_H-1.
  - Exactly IMG_W*IMG_H outputs per frame.
- Counters: in_col/in_row and out_col/out_row wrap at IMG_W-1 / IMG_H-1. Widths are clog2 of the parameter.
- Accepted in_sof while in FILL or RUN: abort the current frame and restart as if from IDLE with this pixel. The remaining outputs of the aborted frame are dropped; no out_eof is issued.
- in_sof is ignored during FLUSH because in_ready=0.
- rst asserted mid-frame: everything returns to reset values on the next edge; nothing is emitted afterwards until a new in_sof.
- mode changes mid-frame have no effect until the next accepted in_sof.

Test Plan (IMG_W=4, IMG_H=3 unless noted):
- Uniform frame, all 12'h888, mode=1, continuous valid -> 12 outputs. Interior (row 1, cols 1-2) = 12'hFFF; all others 12'h000. out_sof on output 0, out_eof on output 11. First out_valid occurs 1 cycle after input index 5 is accepted.
- mode=0, pixels 12'h000..12'h00B -> out_data sequence 12'h000..12'h00B with the same alignment. in_ready=0 for exactly 5 FLUSH cycles after the last input.
- mode=1, centre (1,1) = 12'h888, neighbours: top-left/top/top-right = 12'hFFF, all others 12'h000 -> code 8'hE0, out_data = 12'hEEE for index 5.
- Random in_valid gaps (~30% idle) -> identical output sequence to the gap-free run. No output occurs on stalled cycles.
- in_sof re-asserted at input index 7 -> earlier outputs stop, no out_eof. New frame produces a full 12 outputs with out_sof/out_eof.
- rst pulsed during RUN -> next cycle: out_valid=0, in_ready=1, no further outputs until the next in_sof. Default-size (400x300) run must produce 120000 outputs.

Source files
------------

// File: rtl/lbp_pixel_stream_if.sv
// Pixel stream bundle between frame memory reader, the LBP block and VGA.
// Master drives input pixels and observes the processed stream.
interface lbp_pixel_stream_if #(
    parameter int DATA_WIDTH = 12
);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_sof;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_sof;
    logic                  out_eof;

    modport master (
        output in_data, in_valid, in_sof,
        input  in_ready,
        input  out_data, out_valid, out_sof, out_eof
    );

    modport slave (
        input  in_data, in_valid, in_sof,
        output in_ready,
        output out_data, out_valid, out_sof, out_eof
    );
endinterface

// File: rtl/lbp_pixel_stream.sv
// Streaming 3x3 Local Binary Pattern filter over an RGB444 raster.
// Output k is registered together with the acceptance of input k+IMG_W+1.
module lbp_pixel_stream #(
    parameter int IMG_W      = 400,
    parameter int IMG_H      = 300,
    parameter int DATA_WIDTH = 12
) (
    input logic              clk,
    input logic              rst,
    input logic              mode,
    lbp_pixel_stream_if.slave px
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] FILL  = 2'd1;
    localparam logic [1:0] RUN   = 2'd2;
    localparam logic [1:0] FLUSH = 2'd3;

    typedef logic [DATA_WIDTH-1:0] pix_t;

    logic [1:0]    state;
    logic          mode_q;
    logic [CW-1:0] in_col, out_col, cur_col, nxt_col;
    logic [RW-1:0] in_row, out_row, cur_row, nxt_row;
    pix_t          lb1 [IMG_W];
    pix_t          lb2 [IMG_W];
    pix_t          win  [3][3];
    pix_t          nwin [3][3];
    pix_t          pix_in, odata;
    logic [7:0]    code, code_b;
    logic [3:0]    cg;
    logic          acc, start, flush, adv, emit, border, out_last;

    function automatic logic [3:0] gray(input pix_t p);
        logic [7:0] s;
        s = 8'd5 * {4'd0, p[11:8]}
          + 8'd9 * {4'd0, p[7:4]}
          + 8'd2 * {4'd0, p[3:0]};
        return s[7:4];
    endfunction

    assign flush       = (state == FLUSH);
    assign px.in_ready = !flush;
    assign acc         = px.in_valid && px.in_ready;
    assign start       = acc && px.in_sof;
    assign adv   = start || flush
                || (acc && (state == FILL || state == RUN));
    assign emit  = flush || (acc && !px.in_sof && state == RUN);

    // The sof pixel is always raster position 0, whatever the counters hold.
    assign cur_col = start ? '0 : in_col;
    assign cur_row = start ? '0 : in_row;
    assign nxt_col = (cur_col == COL_LAST) ? '0 : cur_col + 1'b1;
    assign nxt_row = (cur_col != COL_LAST) ? cur_row
                   : (cur_row == ROW_LAST) ? '0 : cur_row + 1'b1;

    assign pix_in = flush ? '0 : px.in_data;

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            nwin[i][0] = win[i][1];
            nwin[i][1] = win[i][2];
        end
        nwin[0][2] = lb2[cur_col];
        nwin[1][2] = lb1[cur_col];
        nwin[2][2] = pix_in;
    end

    assign cg   = gray(nwin[1][1]);
    assign code = {gray(nwin[0][0]) >= cg, gray(nwin[0][1]) >= cg,
                   gray(nwin[0][2]) >= cg, gray(nwin[1][2]) >= cg,
                   gray(nwin[2][2]) >= cg, gray(nwin[2][1]) >= cg,
                   gray(nwin[2][0]) >= cg, gray(nwin[1][0]) >= cg};

    assign border = (out_row == '0) || (out_row == ROW_LAST)
                 || (out_col == '0) || (out_col == COL_LAST);
    assign code_b   = border ? 8'h00 : code;
    assign odata    = mode_q ? {3{code_b[7:4]}} : nwin[1][1];
    assign out_last = (out_row == ROW_LAST) && (out_col == COL_LAST);

    always_ff @(posedge clk) begin
        if (adv) begin
            lb1[cur_col] <= pix_in;
            lb2[cur_col] <= lb1[cur_col];
            win          <= nwin;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            mode_q       <= 1'b0;
            in_col       <= '0;
            in_row       <= '0;
            out_col      <= '0;
            out_row      <= '0;
            px.out_data  <= '0;
            px.out_valid <= 1'b0;
            px.out_sof   <= 1'b0;
            px.out_eof   <= 1'b0;
        end else begin
            px.out_valid <= emit;
            px.out_sof   <= emit && out_col == '0 && out_row == '0;
            px.out_eof   <= emit && out_last;
            if (emit) begin
                px.out_data <= odata;
                out_col     <= (out_col == COL_LAST) ? '0 : out_col + 1'b1;
                if (out_col == COL_LAST)
                    out_row <= out_last ? '0 : out_row + 1'b1;
            end
            if (adv) begin
                in_col <= nxt_col;
                in_row <= nxt_row;
            end
            if (start) begin
                state   <= FILL;
                mode_q  <= mode;
                out_col <= '0;
                out_row <= '0;
            end else begin
                unique case (state)
                    FILL:
                        if (acc && cur_row == RW'(1) && cur_col == '0)
                            state <= RUN;
                    RUN:
                        if (acc && cur_row == ROW_LAST && cur_col == COL_LAST)
                            state <= FLUSH;
                    FLUSH:
                        if (out_last)
                            state <= IDLE;
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lbp_pixel_stream.sv
// Directed bench for lbp_pixel_stream on a 4x3 frame.
// Expected pixel sequences are hand-derived constants.
module tb_lbp_pixel_stream;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic mode = 1'b0;

    always #5 clk = ~clk;

    lbp_pixel_stream_if #(.DATA_WIDTH(12)) bus ();

    lbp_pixel_stream #(
        .IMG_W(W), .IMG_H(H), .DATA_WIDTH(12)
    ) dut (
        .clk (clk),
        .rst (rst),
        .mode(mode),
        .px  (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int stall_out = 0;
    int rdy_lo    = 0;
    logic acc_prev = 1'b0;
    logic rdy_prev = 1'b1;

    logic [11:0] cap_d [$];
    logic        cap_s [$];
    logic        cap_e [$];
    int          cap_c [$];
    int          acc_c [$];

    logic [11:0] e_uni [N] = '{12'h000, 12'h000, 12'h000, 12'h000,
                               12'h000, 12'hFFF, 12'hFFF, 12'h000,
                               12'h000, 12'h000, 12'h000, 12'h000};
    logic [11:0] e_pat [N] = '{12'h000, 12'h000, 12'h000, 12'h000,
                               12'h000, 12'hEEE, 12'hFFF, 12'h000,
                               12'h000, 12'h000, 12'h000, 12'h000};
    logic [11:0] p_pat [N] = '{12'hFFF, 12'hFFF, 12'hFFF, 12'h000,
                               12'h000, 12'h888, 12'h000, 12'h000,
                               12'h000, 12'h000, 12'h000, 12'h000};
    logic [11:0] p_uni [N];
    logic [11:0] p_ramp [N];

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        acc_prev <= bus.in_valid && bus.in_ready;
        rdy_prev <= bus.in_ready;
        if (bus.in_valid && bus.in_ready)
            acc_c.push_back(cyc);
    end

    always @(negedge clk) begin
        if (!bus.in_ready)
            rdy_lo++;
        if (bus.out_valid) begin
            cap_d.push_back(bus.out_data);
            cap_s.push_back(bus.out_sof);
            cap_e.push_back(bus.out_eof);
            cap_c.push_back(cyc);
            if (!acc_prev && rdy_prev)
                stall_out++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic put(input logic [11:0] d, input logic s, input int gap);
        @(negedge clk);
        for (int g = 0; g < 3 && gap > 0 && $urandom_range(99) < gap; g++) begin
            bus.in_valid = 1'b0;
            bus.in_sof   = 1'b0;
            @(negedge clk);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_sof   = s;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    // Mode is flipped mid-frame; it must only take effect at the next sof.
    task automatic frame(input logic [11:0] p [N], input int gap,
                         input logic m);
        mode = m;
        for (int i = 0; i < N; i++) begin
            put(p[i], i == 0, gap);
            if (i == 3) mode = ~m;
        end
        idle(12);
    endtask

    task automatic chk_frame(input string tag, input int cb,
                             input logic [11:0] e [N]);
        chk({tag, "_cnt"}, 32'(cap_d.size() - cb), 32'(N));
        if (cap_d.size() - cb == N) begin
            for (int i = 0; i < N; i++) begin
                chk($sformatf("%s_d%0d", tag, i), 32'(cap_d[cb+i]), 32'(e[i]));
                chk($sformatf("%s_sof%0d", tag, i), 32'(cap_s[cb+i]), 32'(i == 0));
                chk($sformatf("%s_eof%0d", tag, i), 32'(cap_e[cb+i]), 32'(i == N-1));
            end
        end
    endtask

    initial begin
        int cb, ab, rb, sb;
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cb, ab, rb, sb;
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_data  = '0;
        for (int i = 0; i < N; i++) begin
            p_uni[i]  = 12'h888;
            p_ramp[i] = 12'(i);
        end

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_ready", 32'(bus.in_ready), 32'(1));
        chk("rst_data", 32'(bus.out_data), 32'(0));
        chk("rst_sof", 32'(bus.out_sof), 32'(0));
        chk("rst_eof", 32'(bus.out_eof), 32'(0));
        rst = 1'b0;
        idle(2);

        cb = cap_d.size();
        ab = acc_c.size();
        frame(p_uni, 0, 1'b1);
        chk_frame("uni", cb, e_uni);
        if (cap_d.size() > cb && acc_c.size() > ab + 5)
            chk("uni_lat", 32'(cap_c[cb]), 32'(acc_c[ab+5] + 1));
        else
            chk("uni_lat", 32'(0), 32'(1));

        cb = cap_d.size();
        rb = rdy_lo;
        ab = acc_c.size();
        frame(p_ramp, 0, 1'b0);
        chk_frame("pass", cb, p_ramp);
        chk("pass_flush", 32'(rdy_lo - rb), 32'(W + 1));
        if (cap_d.size() > cb && acc_c.size() > ab + 5)
            chk("pass_lat", 32'(cap_c[cb]), 32'(acc_c[ab+5] + 1));
        else
            chk("pass_lat", 32'(0), 32'(1));

        cb = cap_d.size();
        frame(p_pat, 0, 1'b1);
        chk_frame("pat", cb, e_pat);

        cb = cap_d.size();
        sb = stall_out;
        frame(p_pat, 30, 1'b1);
        chk_frame("gap", cb, e_pat);
        chk("gap_stall", 32'(stall_out - sb), 32'(0));

        cb = cap_d.size();
        mode = 1'b1;
        for (int i = 0; i < 7; i++) put(12'h888, i == 0, 0);
        for (int i = 0; i < N; i++) put(12'h888, i == 0, 0);
        idle(12);
        chk("abort_cnt", 32'(cap_d.size() - cb), 32'(N + 2));
        if (cap_d.size() - cb == N + 2) begin
            for (int i = 0; i < N + 2; i++) begin
                chk($sformatf("abort_d%0d", i), 32'(cap_d[cb+i]),
                    32'(i < 2 ? 12'h000 : e_uni[i-2]));
                chk($sformatf("abort_sof%0d", i), 32'(cap_s[cb+i]),
                    32'(i == 0 || i == 2));
                chk($sformatf("abort_eof%0d", i), 32'(cap_e[cb+i]),
                    32'(i == N + 1));
            end
        end

        mode = 1'b1;
        for (int i = 0; i < 8; i++) put(12'h888, i == 0, 0);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'(0));
        chk("mid_rst_ready", 32'(bus.in_ready), 32'(1));
        rst = 1'b0;
        cb = cap_d.size();
        for (int i = 0; i < 6; i++) put(12'h888, 1'b0, 0);
        idle(10);
        chk("mid_rst_quiet", 32'(cap_d.size() - cb), 32'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
